// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
package video_timing_pkg;

    // One-hot state bit positions of each axis ring.
    localparam int unsigned N_ST      = 4;
    localparam int unsigned ST_FP     = 0;
    localparam int unsigned ST_SYNC   = 1;
    localparam int unsigned ST_BP     = 2;
    localparam int unsigned ST_ACTIVE = 3;

    // 640x480 default timing.
    localparam int unsigned DEF_W        = 16;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 64;
    localparam int unsigned DEF_H_BP     = 80;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_FP     = 3;
    localparam int unsigned DEF_V_SYNC   = 4;
    localparam int unsigned DEF_V_BP     = 16;
    localparam int unsigned DEF_V_ACTIVE = 480;

    // Slot order of the eight timing fields in the shadow bank.
    localparam int unsigned N_FIELDS    = 8;
    localparam int unsigned F_H_FP      = 0;
    localparam int unsigned F_H_SYNC    = 1;
    localparam int unsigned F_H_BP      = 2;
    localparam int unsigned F_H_ACTIVE  = 3;
    localparam int unsigned F_V_FP      = 4;
    localparam int unsigned F_V_SYNC    = 5;
    localparam int unsigned F_V_BP      = 6;
    localparam int unsigned F_V_ACTIVE  = 7;

    localparam int unsigned CLAMP_W = 32;

    // A zero-length region would break the ring, so zero becomes one.
    function automatic logic [CLAMP_W-1:0] clamp1(input logic [CLAMP_W-1:0] v);
        return (v == '0) ? CLAMP_W'(1) : v;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Runtime timing-configuration port: eight fields, load strobe, pending flag.
interface video_timing_gen_if
    import video_timing_pkg::*;
#(
    parameter int unsigned W = DEF_W
);
    logic [W-2:0] cfg_h_fp;
    logic [W-2:0] cfg_h_sync;
    logic [W-2:0] cfg_h_bp;
    logic [W-2:0] cfg_h_active;
    logic [W-2:0] cfg_v_fp;
    logic [W-2:0] cfg_v_sync;
    logic [W-2:0] cfg_v_bp;
    logic [W-2:0] cfg_v_active;
    logic         cfg_load;
    logic         cfg_pending;

    modport master (
        output cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_h_active,
        output cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_v_active,
        output cfg_load,
        input  cfg_pending
    );

    modport slave (
        input  cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_h_active,
        input  cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_v_active,
        input  cfg_load,
        output cfg_pending
    );
endinterface

// File: rtl/video_timing_axis.sv
// One raster axis: signed position counter plus FP/SYNC/BP/ACTIVE one-hot ring.
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned W      = DEF_W,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned ACTIVE = DEF_H_ACTIVE
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                advance,
    input  logic                load,
    input  logic [W-2:0]        fp,
    input  logic [W-2:0]        sync,
    input  logic [W-2:0]        bp,
    input  logic [W-2:0]        active,
    output logic signed [W-1:0] cnt,
    output logic [N_ST-1:0]     state,
    output logic                wrap,
    output logic signed [W-1:0] cnt_nxt_c,
    output logic [N_ST-1:0]     state_nxt_c
);
    localparam int unsigned         FW        = W - 1;
    localparam logic signed [W-1:0] ONE_S     = W'(1);
    localparam logic signed [W-1:0] RST_CNT   = W'(-(int'(FP + SYNC + BP)));
    localparam logic [N_ST-1:0]     OH_FP     = N_ST'(1 << ST_FP);
    localparam logic [N_ST-1:0]     OH_SYNC   = N_ST'(1 << ST_SYNC);
    localparam logic [N_ST-1:0]     OH_BP     = N_ST'(1 << ST_BP);
    localparam logic [N_ST-1:0]     OH_ACTIVE = N_ST'(1 << ST_ACTIVE);

    logic [FW-1:0]       fp_q, fp_d, sync_q, sync_d, bp_q, bp_d, act_q, act_d;
    logic signed [W-1:0] cnt_q, cnt_d;
    logic [N_ST-1:0]     state_q, state_d;
    logic signed [W-1:0] fp_s, sync_s, bp_s, act_s;
    logic signed [W-1:0] start_c, to_sync_c, to_bp_c, last_c, ld_start_c;

    // Working fields as signed values and the counts at which the ring moves on.
    always_comb begin
        fp_s       = signed'({1'b0, fp_q});
        sync_s     = signed'({1'b0, sync_q});
        bp_s       = signed'({1'b0, bp_q});
        act_s      = signed'({1'b0, act_q});
        start_c    = -(fp_s + sync_s + bp_s);
        to_sync_c  = -(sync_s + bp_s) - ONE_S;
        to_bp_c    = -bp_s - ONE_S;
        last_c     = act_s - ONE_S;
        ld_start_c = -(signed'({1'b0, fp}) + signed'({1'b0, sync}) + signed'({1'b0, bp}));
    end

    // Kept apart from the next-state block: the parent feeds wrap back into load.
    assign wrap = advance && (cnt_q == last_c);

    // Next count/state: load restarts on new timing, otherwise step or wrap.
    always_comb begin
        fp_d    = fp_q;
        sync_d  = sync_q;
        bp_d    = bp_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (load) begin
            fp_d    = fp;
            sync_d  = sync;
            bp_d    = bp;
            act_d   = active;
            cnt_d   = ld_start_c;
            state_d = OH_FP;
        end else if (advance) begin
            if (cnt_q == last_c) begin
                cnt_d   = start_c;
                state_d = OH_FP;
            end else begin
                cnt_d = cnt_q + ONE_S;
                if (cnt_q == to_sync_c) begin
                    state_d = OH_SYNC;
                end else if (cnt_q == to_bp_c) begin
                    state_d = OH_BP;
                end else if (cnt_q == -ONE_S) begin
                    state_d = OH_ACTIVE;
                end
            end
        end
    end

    // Counter, ring and working-timing registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fp_q    <= FW'(FP);
            sync_q  <= FW'(SYNC);
            bp_q    <= FW'(BP);
            act_q   <= FW'(ACTIVE);
            cnt_q   <= RST_CNT;
            state_q <= OH_FP;
        end else begin
            fp_q    <= fp_d;
            sync_q  <= sync_d;
            bp_q    <= bp_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign cnt         = cnt_q;
    assign state       = state_q;
    assign cnt_nxt_c   = cnt_d;
    assign state_nxt_c = state_d;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with frame-boundary reprogrammable timing.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned W         = DEF_W,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    video_timing_gen_if.slave   cfg,
    output logic                hsync,
    output logic                vsync,
    output logic                data_en,
    output logic signed [W-1:0] xpos,
    output logic signed [W-1:0] ypos,
    output logic                line_start,
    output logic                frame_start
);
    localparam int unsigned FW = W - 1;
    localparam logic [N_FIELDS-1:0][FW-1:0] RST_SHADOW = {
        FW'(V_ACTIVE), FW'(V_BP), FW'(V_SYNC), FW'(V_FP),
        FW'(H_ACTIVE), FW'(H_BP), FW'(H_SYNC), FW'(H_FP)
    };

    logic [N_FIELDS-1:0][FW-1:0] shadow_q, shadow_d, new_c, apply_c;
    logic                        pending_q, pending_d;
    logic                        hsync_q, hsync_d, vsync_q, vsync_d, data_en_q, data_en_d;
    logic                        line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic signed [W-1:0]         h_cnt, v_cnt, h_cnt_nxt, v_cnt_nxt, h_cnt_sel, v_cnt_sel;
    logic [N_ST-1:0]             h_state, v_state, h_state_nxt, v_state_nxt, h_st_sel, v_st_sel;
    logic                        h_wrap, v_wrap, frame_wrap_c;

    // Incoming fields with zero clamped; a load on the wrap cycle bypasses the shadow.
    always_comb begin
        new_c[F_H_FP]     = FW'(clamp1(CLAMP_W'(cfg.cfg_h_fp)));
        new_c[F_H_SYNC]   = FW'(clamp1(CLAMP_W'(cfg.cfg_h_sync)));
        new_c[F_H_BP]     = FW'(clamp1(CLAMP_W'(cfg.cfg_h_bp)));
        new_c[F_H_ACTIVE] = FW'(clamp1(CLAMP_W'(cfg.cfg_h_active)));
        new_c[F_V_FP]     = FW'(clamp1(CLAMP_W'(cfg.cfg_v_fp)));
        new_c[F_V_SYNC]   = FW'(clamp1(CLAMP_W'(cfg.cfg_v_sync)));
        new_c[F_V_BP]     = FW'(clamp1(CLAMP_W'(cfg.cfg_v_bp)));
        new_c[F_V_ACTIVE] = FW'(clamp1(CLAMP_W'(cfg.cfg_v_active)));
        apply_c           = cfg.cfg_load ? new_c : shadow_q;
    end

    assign frame_wrap_c = v_wrap;

    video_timing_axis #(
        .W(W), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE)
    ) u_h_axis (
        .clk         (clk),
        .resetn      (resetn),
        .advance     (en),
        .load        (frame_wrap_c),
        .fp          (apply_c[F_H_FP]),
        .sync        (apply_c[F_H_SYNC]),
        .bp          (apply_c[F_H_BP]),
        .active      (apply_c[F_H_ACTIVE]),
        .cnt         (h_cnt),
        .state       (h_state),
        .wrap        (h_wrap),
        .cnt_nxt_c   (h_cnt_nxt),
        .state_nxt_c (h_state_nxt)
    );

    video_timing_axis #(
        .W(W), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE)
    ) u_v_axis (
        .clk         (clk),
        .resetn      (resetn),
        .advance     (h_wrap),
        .load        (frame_wrap_c),
        .fp          (apply_c[F_V_FP]),
        .sync        (apply_c[F_V_SYNC]),
        .bp          (apply_c[F_V_BP]),
        .active      (apply_c[F_V_ACTIVE]),
        .cnt         (v_cnt),
        .state       (v_state),
        .wrap        (v_wrap),
        .cnt_nxt_c   (v_cnt_nxt),
        .state_nxt_c (v_state_nxt)
    );

    // Shadow capture; last load wins, a load landing on the wrap never pends.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (cfg.cfg_load) begin
            shadow_d  = new_c;
            pending_d = ~frame_wrap_c;
        end else if (frame_wrap_c) begin
            pending_d = 1'b0;
        end
    end

    // Outputs follow the position the counters move to; when frozen, the current one.
    always_comb begin
        h_cnt_sel     = en ? h_cnt_nxt   : h_cnt;
        v_cnt_sel     = en ? v_cnt_nxt   : v_cnt;
        h_st_sel      = en ? h_state_nxt : h_state;
        v_st_sel      = en ? v_state_nxt : v_state;
        hsync_d       = h_st_sel[ST_SYNC] ^ ~HSYNC_POL;
        vsync_d       = v_st_sel[ST_SYNC] ^ ~VSYNC_POL;
        data_en_d     = h_st_sel[ST_ACTIVE] & v_st_sel[ST_ACTIVE];
        line_start_d  = (h_cnt_sel == '0);
        frame_start_d = (h_cnt_sel == '0) && (v_cnt_sel == '0);
    end

    // Config and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_q      <= RST_SHADOW;
            pending_q     <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            data_en_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            data_en_q     <= data_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign cfg.cfg_pending = pending_q;
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign data_en         = data_en_q;
    assign xpos            = h_cnt;
    assign ypos            = v_cnt;
    assign line_start      = line_start_q;
    assign frame_start     = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen against a position-based raster model.
module tb_video_timing_gen;
    localparam int unsigned W = 16;
    localparam int HFP = 2, HS = 3, HBP = 4, HA = 8;
    localparam int VFP = 1, VS = 2, VBP = 1, VA = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    video_timing_gen_if #(.W(W)) ifa ();
    video_timing_gen_if #(.W(W)) ifb ();

    logic hs_a, vs_a, de_a, ls_a, fs_a;
    logic hs_b, vs_b, de_b, ls_b, fs_b;
    logic signed [W-1:0] xa, ya, xb, yb;

    video_timing_gen #(
        .W(W), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
        .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_a (
        .clk(clk), .resetn(resetn), .en(en), .cfg(ifa),
        .hsync(hs_a), .vsync(vs_a), .data_en(de_a), .xpos(xa), .ypos(ya),
        .line_start(ls_a), .frame_start(fs_a)
    );

    video_timing_gen #(
        .W(W), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
        .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .resetn(resetn), .en(en), .cfg(ifb),
        .hsync(hs_b), .vsync(vs_b), .data_en(de_b), .xpos(xb), .ypos(yb),
        .line_start(ls_b), .frame_start(fs_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: working timing, shadow, pending flag and raster position.
    int  wk[8];
    int  sh[8];
    int  cfgv[8];
    bit  pend;
    int  mx, my;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int c1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        wk   = '{HFP, HS, HBP, HA, VFP, VS, VBP, VA};
        sh   = wk;
        pend = 1'b0;
        mx   = -(HFP + HS + HBP);
        my   = -(VFP + VS + VBP);
    endtask

    task automatic model_step(input bit e, input bit ld);
        bit hwr, fwr;
        int lv[8];
        hwr = e && (mx == wk[3] - 1);
        fwr = hwr && (my == wk[7] - 1);
        for (int i = 0; i < 8; i++) lv[i] = c1(cfgv[i]);
        if (fwr) begin
            if (ld) wk = lv;
            else    wk = sh;
            mx = -(wk[0] + wk[1] + wk[2]);
            my = -(wk[4] + wk[5] + wk[6]);
        end else if (hwr) begin
            mx = -(wk[0] + wk[1] + wk[2]);
            my = my + 1;
        end else if (e) begin
            mx = mx + 1;
        end
        if (ld) begin
            sh   = lv;
            pend = !fwr;
        end else if (fwr) begin
            pend = 1'b0;
        end
    endtask

    task automatic check_all();
        bit hact, vact;
        hact = (mx >= -(wk[1] + wk[2])) && (mx <= -wk[2] - 1);
        vact = (my >= -(wk[5] + wk[6])) && (my <= -wk[6] - 1);
        check("xpos", xa, mx);
        check("ypos", ya, my);
        check("hsync", hs_a, hact);
        check("vsync", vs_a, vact);
        check("data_en", de_a, (mx >= 0) && (my >= 0));
        check("line_start", ls_a, mx == 0);
        check("frame_start", fs_a, (mx == 0) && (my == 0));
        check("cfg_pending", ifa.cfg_pending, pend);
        check("hsync_lowpol", hs_b, !hact);
        check("vsync_lowpol", vs_b, !vact);
        check("xpos_lowpol", xb, mx);
    endtask

    task automatic drive_cfg(input bit ld);
        ifa.cfg_h_fp = 15'(cfgv[0]); ifb.cfg_h_fp = 15'(cfgv[0]);
        ifa.cfg_h_sync = 15'(cfgv[1]); ifb.cfg_h_sync = 15'(cfgv[1]);
        ifa.cfg_h_bp = 15'(cfgv[2]); ifb.cfg_h_bp = 15'(cfgv[2]);
        ifa.cfg_h_active = 15'(cfgv[3]); ifb.cfg_h_active = 15'(cfgv[3]);
        ifa.cfg_v_fp = 15'(cfgv[4]); ifb.cfg_v_fp = 15'(cfgv[4]);
        ifa.cfg_v_sync = 15'(cfgv[5]); ifb.cfg_v_sync = 15'(cfgv[5]);
        ifa.cfg_v_bp = 15'(cfgv[6]); ifb.cfg_v_bp = 15'(cfgv[6]);
        ifa.cfg_v_active = 15'(cfgv[7]); ifb.cfg_v_active = 15'(cfgv[7]);
        ifa.cfg_load = ld; ifb.cfg_load = ld;
    endtask

    // Called at a falling edge: drive, advance the model, compare at the next falling edge.
    task automatic step(input bit e, input bit ld);
        en = e;
        drive_cfg(ld);
        model_step(e, ld);
        @(negedge clk);
        drive_cfg(1'b0);
        check_all();
    endtask

    task automatic set_cfg(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
        cfgv = '{a0, a1, a2, a3, b0, b1, b2, b3};
    endtask

    // Cycles between two consecutive frame_start pulses (-1 if not seen in time).
    task automatic fs_period(output int per);
        int k;
        per = -1;
        k = 0;
        while (k < 400) begin
            step(1'b1, 1'b0);
            k++;
            if (fs_a) break;
        end
        if (fs_a !== 1'b1) return;
        k = 0;
        while (k < 400) begin
            step(1'b1, 1'b0);
            k++;
            if (fs_a) begin
                per = k;
                return;
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        int first_fs, second_fs, de_cnt, vs_cnt, hs_cnt, n, per;
        int sx, sy;
        logic sh_s, sd_s;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        drive_cfg(1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check_all();

        // Free run from reset with the parameter timing.
        resetn = 1'b1;
        first_fs = -1; second_fs = -1; de_cnt = 0; vs_cnt = 0; hs_cnt = 0;
        for (int i = 1; i <= 77 + 2 * 119; i++) begin
            step(1'b1, 1'b0);
            if (fs_a && first_fs < 0) first_fs = i;
            else if (fs_a && second_fs < 0) second_fs = i;
            if (i >= 77 && i < 77 + 119) begin
                de_cnt += int'(de_a);
                vs_cnt += int'(vs_a);
                hs_cnt += int'(hs_a);
            end
        end
        check("first_frame_start", first_fs, 77);
        check("frame_period", second_fs - first_fs, 119);
        check("data_en_per_frame", de_cnt, 24);
        check("vsync_per_frame", vs_cnt, 34);
        check("hsync_per_frame", hs_cnt, 21);

        // Mid-frame load of a narrower line: pends until the frame ends.
        set_cfg(2, 3, 4, 4, 1, 2, 1, 3);
        step(1'b1, 1'b1);
        check("pending_after_load", ifa.cfg_pending, 1);
        n = 0;
        while (ifa.cfg_pending === 1'b1 && n < 300) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("pending_cycles", n, 41);
        fs_period(per);
        check("frame_period_13px", per, 91);

        // Load exactly on the frame-wrap cycle.
        set_cfg(2, 3, 4, 5, 1, 2, 1, 3);
        n = 0;
        while (!(mx == wk[3] - 1 && my == wk[7] - 1) && n < 300) begin
            step(1'b1, 1'b0);
            n++;
        end
        step(1'b1, 1'b1);
        check("pending_on_wrap", ifa.cfg_pending, 0);
        check("xpos_after_wrap_load", xa, -9);
        fs_period(per);
        check("frame_period_14px", per, 98);

        // All-zero fields clamp to 1/1/1/1, then a 5-cycle freeze.
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1);
        n = 0;
        while (ifa.cfg_pending === 1'b1 && n < 300) begin
            step(1'b1, 1'b0);
            n++;
        end
        repeat (6) step(1'b1, 1'b0);
        sx = int'(xa); sy = int'(ya); sh_s = hs_a; sd_s = de_a;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check("frozen_xpos", xa, sx);
            check("frozen_ypos", ya, sy);
            check("frozen_hsync", hs_a, sh_s);
            check("frozen_data_en", de_a, sd_s);
        end
        fs_period(per);
        check("frame_period_min", per, 16);

        // Random enables, loads and field values.
        for (int i = 0; i < 2500; i++) begin
            bit e, ld;
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 149) == 0);
            if (e && mx == wk[3] - 1 && my == wk[7] - 1 && $urandom_range(0, 3) == 0) ld = 1'b1;
            if (ld) begin
                for (int f = 0; f < 8; f++) cfgv[f] = int'($urandom_range(0, 6));
            end
            step(e, ld);
        end

        // Async reset mid-line with a load still pending.
        n = 0;
        while (!(mx > -3 && mx < wk[3] - 2) && n < 300) begin
            step(1'b1, 1'b0);
            n++;
        end
        set_cfg(5, 5, 5, 5, 5, 5, 5, 5);
        step(1'b1, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        resetn = 1'b1;
        first_fs = -1;
        for (int i = 1; i <= 130; i++) begin
            step(1'b1, 1'b0);
            if (fs_a && first_fs < 0) first_fs = i;
        end
        check("first_frame_start_after_reset", first_fs, 77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the picosoc video path. It is the successor to the fixed 640x480 timing block. It produces hsync/vsync/data_en and signed pixel coordinates from a single pixel clock, with configurable sync polarity and a pause input. Its timing fields are reprogrammable at runtime through shadow registers, which take effect only at a frame boundary so the display never sees a torn frame.

## Interface
Parameters:
- `W`, 16: counter/coordinate width (signed).
- `H_FP`/`H_SYNC`/`H_BP`/`H_ACTIVE`, 16/64/80/640: reset-time horizontal timing, in pixels.
- `V_FP`/`V_SYNC`/`V_BP`/`V_ACTIVE`, 3/4/16/480: reset-time vertical timing, in lines.
- `HSYNC_POL`, `VSYNC_POL`, 1/1: 1 means sync is driven high while asserted.

Ports:
- `clk`  in  1  pixel clock; one clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; low freezes all counters and outputs.
- `cfg_h_fp`, `cfg_h_sync`, `cfg_h_bp`, `cfg_h_active`  in  W-1 each  new horizontal timing.
- `cfg_v_fp`, `cfg_v_sync`, `cfg_v_bp`, `cfg_v_active`  in  W-1 each  new vertical timing.
- `cfg_load`  in  1  single-cycle strobe; captures all eight `cfg_*` fields.
- `cfg_pending`  out  1  captured config not yet applied.
- `hsync`, `vsync`  out  1  sync outputs, polarity per parameter.
- `data_en`  out  1  high when both axes are in their active region.
- `xpos`, `ypos`  out  W  signed; 0..ACTIVE-1 in the active region, negative in blanking.
- `line_start`  out  1  one-cycle pulse on the first active pixel of every line (any vertical state).
- `frame_start`  out  1  one-cycle pulse on pixel (0,0).

## Operation
- Each axis is a four-state ring visited in order FP -> SYNC -> BP -> ACTIVE -> FP, one-hot.
- Each axis counter runs from -(FP+SYNC+BP) up to ACTIVE-1, then wraps.
- State transitions happen when the counter reaches:
  - -(SYNC+BP)-1 (FP -> SYNC),
  - -BP-1 (SYNC -> BP),
  - -1 (BP -> ACTIVE),
  - ACTIVE-1 (ACTIVE -> FP).
- The horizontal counter advances every cycle while `en` is high.
- The vertical counter advances only on the cycle the horizontal counter wraps (end of line).
- Frame wrap means a horizontal wrap coinciding with vertical ACTIVE-1.
- Config path:
  - `cfg_load` copies all `cfg_*` fields into shadow registers and sets `cfg_pending`.
  - A second load while pending overwrites the shadow; last load wins.
  - At the next frame wrap the shadow becomes the working timing, `cfg_pending` clears, and both counters restart at -(FP+SYNC+BP) of the new values.
  - If `cfg_load` coincides with a frame wrap, the newly presented values apply at that wrap and `cfg_pending` stays 0.
- Field rule: any field value of 0 is clamped to 1 on capture. Arithmetic is done in W bits; callers guarantee FP+SYNC+BP+ACTIVE < 2^(W-1).
- `hsync` = h_state==SYNC, XOR'ed with !HSYNC_POL; `vsync` is formed the same way from the vertical state and VSYNC_POL.

## Timing
- All outputs are registered and mutually aligned: in any cycle, `xpos`/`ypos` are the coordinates of the pixel that `data_en`/`hsync`/`vsync` describe.
- Reset values:
  - h and v counters at -(FP+SYNC+BP) from the parameters; state FP on both axes.
  - `hsync` = !HSYNC_POL, `vsync` = !VSYNC_POL.
  - `data_en` = 0, `line_start` = 0, `frame_start` = 0, `cfg_pending` = 0.
  - Shadow registers = parameter values.
- First `frame_start` after reset release with `en`=1: (H_TOT × (V_FP+V_SYNC+V_BP)) + (H_FP+H_SYNC+H_BP) cycles, where H_TOT = sum of the four horizontal fields.
- `en` low: no counter, state or output changes. Pulses hold their current value, so `en` must be low for at least one cycle before a pulse is considered stale.
- Reset asserted mid-frame: immediate async return to reset values. A pending config is discarded.

## Structure
- Package `video_timing_pkg`:
  - state bit indices `ST_FP=0`, `ST_SYNC=1`, `ST_BP=2`, `ST_ACTIVE=3`;
  - the 640x480 default constants;
  - a `clamp1` function.
- Sub-module `video_timing_axis`, instantiated twice (horizontal and vertical):
  - inputs: `clk`, `resetn`, `advance`, `load`, four timing fields;
  - outputs: signed count, one-hot state, `wrap`.
- The top level holds the shadow registers, the pending flag, the polarity XOR and the pulse generation.

## Test plan
All scenarios use small parameters H 2/3/4/8 (17 px/line) and V 1/2/1/3 (7 lines, 119-cycle frame) unless noted.
- Reset release with `en`=1 → `xpos` runs -9..7; `hsync` is asserted for exactly 3 cycles at `xpos` -7..-5; `frame_start` first fires at cycle 17*4+9 = 77 and then every 119 cycles.
- `data_en` → high for exactly 8 cycles on each of 3 lines per frame (24 per frame); `vsync` is asserted for 34 cycles.
- `HSYNC_POL`=0, `VSYNC_POL`=0 → sync outputs idle high after reset and pulse low with the same widths.
- `cfg_load` mid-frame with H_ACTIVE=4 → `cfg_pending`=1; the current frame completes at 17 px/line; the following frame runs at 13 px/line and `cfg_pending`=0.
- `cfg_load` on the frame-wrap cycle → new timing applies immediately; `cfg_pending` is never set.
- `cfg_load` with all fields 0, then toggle `en` low for 5 cycles → timing becomes 1/1/1/1 (4 px/line, 16-cycle frame); the outputs are frozen for those 5 cycles. Async reset mid-line → every output returns to its reset value without waiting for a clock edge.
